// File: rtl/uart_pkg.sv
// Shared types and source indices for the UART interrupt controller.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } irq_state_e;

    localparam int unsigned IRQ_TX_EMPTY   = 0;
    localparam int unsigned IRQ_TX_FULL    = 1;
    localparam int unsigned IRQ_RX_VALID   = 2;
    localparam int unsigned IRQ_RX_OVERRUN = 3;

endpackage

// File: rtl/uart_irq_ctrl_if.sv
// Status/config inputs and irq/id/ack handshake of the UART interrupt controller.
interface uart_irq_ctrl_if #(
    parameter int unsigned N_SRC = 4
);
    localparam int unsigned ID_W = $clog2(N_SRC);

    logic [N_SRC-1:0] status_in;
    logic [N_SRC-1:0] edge_mode;
    logic [N_SRC-1:0] irq_mask;
    logic             irq_ack;
    logic             irq;
    logic [ID_W-1:0]  irq_id;
    logic [N_SRC-1:0] pending;

    modport master (
        output status_in, edge_mode, irq_mask, irq_ack,
        input  irq, irq_id, pending
    );

    modport slave (
        input  status_in, edge_mode, irq_mask, irq_ack,
        output irq, irq_id, pending
    );

endinterface

// File: rtl/uart_irq_ctrl_prio_enc.sv
// Combinational lowest-index-first priority encoder with an any-valid flag.
module irq_prio_enc #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    output logic [ID_W-1:0] id,
    output logic            valid
);

    always_comb begin
        id    = '0;
        valid = |req;
        // Scan high to low so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/uart_irq_ctrl.sv
// UART interrupt controller: edge/level capture, masking, fixed priority and
// a single irq line with id/ack handshake and post-ack holdoff.
module uart_irq_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned N_SRC          = 4,
    parameter int unsigned HOLDOFF_CYCLES = 2
) (
    input logic            clk,
    input logic            rst_n,
    uart_irq_ctrl_if.slave bus
);

    localparam int unsigned ID_W = $clog2(N_SRC);

    irq_state_e       state_q, state_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] status_prev_q;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic             irq_q;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] clr;
    logic [ID_W-1:0]  top_id;
    logic             req_valid;
    logic             ack_acc;

    irq_prio_enc #(
        .N    (N_SRC),
        .ID_W (ID_W)
    ) u_prio_enc (
        .req   (req),
        .id    (top_id),
        .valid (req_valid)
    );

    always_comb begin
        rise    = bus.status_in & ~status_prev_q;
        req     = pending_q & bus.irq_mask;
        ack_acc = bus.irq_ack && (state_q == ASSERT);
        clr     = '0;
        if (ack_acc) begin
            clr[irq_id_q] = 1'b1;
        end
        // Edge sources: rise wins over a same-cycle ack clear. Level sources track the flag.
        pending_d = (bus.edge_mode & ((pending_q & ~clr) | rise))
                  | (~bus.edge_mode & bus.status_in);
    end

    always_comb begin
        state_d    = state_q;
        irq_id_d   = irq_id_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d  = ASSERT;
                    irq_id_d = top_id;
                end
            end
            ASSERT: begin
                if (bus.irq_ack) begin
                    hold_cnt_d = 8'(HOLDOFF_CYCLES);
                    state_d    = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
                end else if (!bus.irq_mask[irq_id_q]) begin
                    state_d = IDLE;
                end
            end
            HOLDOFF: begin
                if (hold_cnt_q <= 8'd1) begin
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            irq_id_q      <= '0;
            pending_q     <= '0;
            status_prev_q <= '0;
            hold_cnt_q    <= '0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            irq_id_q      <= irq_id_d;
            pending_q     <= pending_d;
            status_prev_q <= bus.status_in;
            hold_cnt_q    <= hold_cnt_d;
            irq_q         <= (state_d == ASSERT);
        end
    end

    assign bus.irq     = irq_q;
    assign bus.irq_id  = irq_id_q;
    assign bus.pending = pending_q;

`ifndef SYNTHESIS
    if (N_SRC < 2) begin : g_bad_n_src
        $error("uart_irq_ctrl: N_SRC must be at least 2");
    end
    if (HOLDOFF_CYCLES > 255) begin : g_bad_holdoff
        $error("uart_irq_ctrl: HOLDOFF_CYCLES must not exceed 255");
    end

    a_id_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (irq_q && $past(irq_q)) |-> (irq_id_q == $past(irq_id_q)));
`endif

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Self-checking bench for uart_irq_ctrl: directed scenarios plus randomized
// traffic against a cycle-level reference model, on holdoff 2 and holdoff 0 builds.
module tb_uart_irq_ctrl;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] s_in = '0;
    logic [3:0] mode = '0;
    logic [3:0] mask = '0;
    logic       ack = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    uart_irq_ctrl_if #(.N_SRC(4)) bus0 ();
    uart_irq_ctrl_if #(.N_SRC(4)) bus1 ();

    assign bus0.status_in = s_in;
    assign bus0.edge_mode = mode;
    assign bus0.irq_mask  = mask;
    assign bus0.irq_ack   = ack;
    assign bus1.status_in = s_in;
    assign bus1.edge_mode = mode;
    assign bus1.irq_mask  = mask;
    assign bus1.irq_ack   = ack;

    uart_irq_ctrl #(.N_SRC(4), .HOLDOFF_CYCLES(2)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    uart_irq_ctrl #(.N_SRC(4), .HOLDOFF_CYCLES(0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    // Reference model: an "active" request flag plus a count of edges still blocked after ack.
    int         hold [2] = '{2, 0};
    logic [3:0] m_prev [2];
    logic [3:0] m_pend [2];
    bit         m_active [2];
    int         m_id [2];
    int         m_block [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_prev[k]   = '0;
            m_pend[k]   = '0;
            m_active[k] = 1'b0;
            m_id[k]     = 0;
            m_block[k]  = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic [3:0] np;
            logic [3:0] req;
            bit         acc;
            int         top;
            req = m_pend[k] & mask;
            acc = ack && m_active[k];
            for (int i = 0; i < 4; i++) begin
                if (mode[i]) np[i] = (m_pend[k][i] && !(acc && m_id[k] == i))
                                     || (s_in[i] && !m_prev[k][i]);
                else         np[i] = s_in[i];
            end
            if (m_active[k]) begin
                if (acc) begin
                    m_active[k] = 1'b0;
                    m_block[k]  = hold[k];
                end else if (!mask[m_id[k]]) begin
                    m_active[k] = 1'b0;
                end
            end else if (m_block[k] > 0) begin
                m_block[k]--;
            end else if (req != 0) begin
                top = 0;
                while (!req[top]) top++;
                m_active[k] = 1'b1;
                m_id[k]     = top;
            end
            m_pend[k] = np;
            m_prev[k] = s_in;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] s, input logic [3:0] md, input logic [3:0] mk);
        rst_n = 1'b0;
        s_in  = s;
        mode  = md;
        mask  = mk;
        ack   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_in  = 4'hF;
        mode  = 4'hF;
        mask  = 4'hF;
        ack   = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if ({bus0.irq, bus0.irq_id, bus0.pending} !== 7'd0)
            $display("FAIL reset_state: got irq=%b id=%0d pend=%b want all 0",
                     bus0.irq, bus0.irq_id, bus0.pending);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus0.pending !== 4'hF || bus0.irq !== 1'b0)
            $display("FAIL reset_release_pend: got pend=%b irq=%b want 1111/0",
                     bus0.pending, bus0.irq);
        else n_pass++;
        tick();
        n_checks++;
        if (bus0.irq !== 1'b1 || bus0.irq_id !== 2'd0)
            $display("FAIL reset_release_irq: got irq=%b id=%0d want 1/0", bus0.irq, bus0.irq_id);
        else n_pass++;
        n_checks++;
        if (bus1.irq !== 1'b1 || bus1.irq_id !== 2'd0)
            $display("FAIL reset_release_irq_h0: got irq=%b id=%0d want 1/0",
                     bus1.irq, bus1.irq_id);
        else n_pass++;
    endtask

    task automatic test_priority_chain();
        int  lat;
        bit  seen;
        do_reset(4'h0, 4'hF, 4'hF);
        tick();
        s_in = 4'b1010;
        tick();
        n_checks++;
        if (bus0.pending !== 4'b1010)
            $display("FAIL chain_pend: got %b want 1010", bus0.pending);
        else n_pass++;
        tick();
        n_checks++;
        if (bus0.irq !== 1'b1 || bus0.irq_id !== 2'd1)
            $display("FAIL chain_first: got irq=%b id=%0d want 1/1", bus0.irq, bus0.irq_id);
        else n_pass++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++;
        if (bus0.irq !== 1'b0 || bus0.pending !== 4'b1000)
            $display("FAIL chain_ack1: got irq=%b pend=%b want 0/1000", bus0.irq, bus0.pending);
        else n_pass++;
        lat = 0;
        while (bus0.irq !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat != 3 || bus0.irq_id !== 2'd3)
            $display("FAIL chain_second: got gap=%0d id=%0d want 3/3", lat, bus0.irq_id);
        else n_pass++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus0.irq !== 1'b0) seen = 1'b1;
            tick();
        end
        n_checks++;
        if (seen || bus0.pending !== 4'b0000)
            $display("FAIL chain_done: got spurious=%b pend=%b want 0/0000", seen, bus0.pending);
        else n_pass++;
    endtask

    task automatic test_level();
        int lat;
        bit seen;
        do_reset(4'h0, 4'h0, 4'hF);
        tick();
        s_in[IRQ_RX_VALID] = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus0.irq !== 1'b1 || bus0.irq_id !== 2'd2)
            $display("FAIL level_first: got irq=%b id=%0d want 1/2", bus0.irq, bus0.irq_id);
        else n_pass++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++;
        if (bus0.irq !== 1'b0 || bus0.pending !== 4'b0100)
            $display("FAIL level_ack: got irq=%b pend=%b want 0/0100", bus0.irq, bus0.pending);
        else n_pass++;
        lat = 0;
        while (bus0.irq !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat != 3 || bus0.irq_id !== 2'd2)
            $display("FAIL level_reassert: got gap=%0d id=%0d want 3/2", lat, bus0.irq_id);
        else n_pass++;
        ack  = 1'b1;
        s_in = 4'h0;
        tick();
        ack  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus0.irq !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen || bus0.pending !== 4'h0)
            $display("FAIL level_drop: got spurious=%b pend=%b want 0/0000", seen, bus0.pending);
        else n_pass++;
    endtask

    task automatic test_set_clear();
        int lat;
        do_reset(4'h0, 4'hF, 4'hF);
        tick();
        s_in = 4'b0001;
        tick();
        tick();
        s_in = 4'b0000;
        tick();
        s_in = 4'b0001;
        ack  = 1'b1;
        tick();
        ack  = 1'b0;
        n_checks++;
        if (bus0.pending[0] !== 1'b1 || bus0.irq !== 1'b0)
            $display("FAIL setclr_pend: got pend0=%b irq=%b want 1/0", bus0.pending[0], bus0.irq);
        else n_pass++;
        lat = 0;
        while (bus0.irq !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat != 3 || bus0.irq_id !== 2'd0)
            $display("FAIL setclr_reassert: got gap=%0d id=%0d want 3/0", lat, bus0.irq_id);
        else n_pass++;
    endtask

    task automatic test_mask_withdraw();
        do_reset(4'h0, 4'hF, 4'hF);
        tick();
        s_in = 4'b0010;
        tick();
        tick();
        mask = 4'b1101;
        tick();
        n_checks++;
        if (bus0.irq !== 1'b0 || bus0.pending !== 4'b0010)
            $display("FAIL mask_withdraw: got irq=%b pend=%b want 0/0010", bus0.irq, bus0.pending);
        else n_pass++;
        mask = 4'hF;
        tick();
        n_checks++;
        if (bus0.irq !== 1'b1 || bus0.irq_id !== 2'd1)
            $display("FAIL mask_reenable: got irq=%b id=%0d want 1/1", bus0.irq, bus0.irq_id);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset(4'h0, 4'hF, 4'hF);
        tick();
        s_in = 4'b0001;
        tick();
        tick();
        ack = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus0.irq, bus0.irq_id, bus0.pending, bus1.irq, bus1.irq_id, bus1.pending} !== 14'd0)
            $display("FAIL async_reset: got irq=%b/%b pend=%b/%b want all 0",
                     bus0.irq, bus1.irq, bus0.pending, bus1.pending);
        else n_pass++;
        model_reset();
        ack  = 1'b0;
        mode = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus1.irq !== 1'b1)
            $display("FAIL h0_assert: got irq=%b want 1", bus1.irq);
        else n_pass++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++;
        if (bus1.irq !== 1'b0)
            $display("FAIL h0_ack: got irq=%b want 0", bus1.irq);
        else n_pass++;
        tick();
        n_checks++;
        if (bus1.irq !== 1'b1 || bus1.irq_id !== 2'd0)
            $display("FAIL h0_reassert: got irq=%b id=%0d want 1/0", bus1.irq, bus1.irq_id);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 3; seg++) begin
            do_reset(4'h0, 4'($urandom), 4'hF);
            for (int c = 0; c < 120; c++) begin
                if ($urandom_range(0, 2) == 0) s_in = 4'($urandom);
                if ($urandom_range(0, 9) == 0) mask = 4'($urandom);
                ack = ($urandom_range(0, 3) == 0);
                tick();
                n_checks++;
                if (bus0.irq !== m_active[0] || bus0.pending !== m_pend[0]
                    || (m_active[0] && bus0.irq_id !== 2'(m_id[0])))
                    $display("FAIL rand_h2 c=%0d: got irq=%b id=%0d pend=%b want %b/%0d/%b",
                             c, bus0.irq, bus0.irq_id, bus0.pending,
                             m_active[0], m_id[0], m_pend[0]);
                else n_pass++;
                n_checks++;
                if (bus1.irq !== m_active[1] || bus1.pending !== m_pend[1]
                    || (m_active[1] && bus1.irq_id !== 2'(m_id[1])))
                    $display("FAIL rand_h0 c=%0d: got irq=%b id=%0d pend=%b want %b/%0d/%b",
                             c, bus1.irq, bus1.irq_id, bus1.pending,
                             m_active[1], m_id[1], m_pend[1]);
                else n_pass++;
            end
            ack = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_priority_chain();
        test_level();
        test_set_clear();
        test_mask_withdraw();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
